amm_cmd_buffer: RTL

Avalon-MM command buffer and outstanding-read limiter placed between the JTAG-side Avalon-MM master and the `amm_conv` width converter. It decouples the master from downstream `waitrequest` stalls by queuing up to `DEPTH` commands. It caps in-flight reads at `MAX_PEND`, so the demux/slave fabric never receives more reads than it can return. Read responses are forwarded upstream with one register stage.

---
 rtl/amm_cmd_pkg.sv | 20 ++
 rtl/avalon_mm_if.sv | 26 ++
 rtl/amm_sc_fifo.sv | 65 ++++++
 rtl/amm_cmd_buffer.sv | 114 +++++++++++
 4 files changed

// File: rtl/amm_cmd_pkg.sv
// rtl/amm_cmd_pkg.sv - shared command type and width helpers for the Avalon-MM command buffer
package amm_cmd_pkg;

  localparam int AMM_ADDR_W = 32;
  localparam int AMM_DATA_W = 16;

  // One byteenable bit per data byte.
  function automatic int amm_be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Queued command as seen at default widths: {we, addr, wdata, be}.
  typedef struct packed {
    logic                    we;
    logic [AMM_ADDR_W-1:0]   addr;
    logic [AMM_DATA_W-1:0]   wdata;
    logic [AMM_DATA_W/8-1:0] be;
  } amm_cmd_t;

endpackage

// File: rtl/avalon_mm_if.sv
// rtl/avalon_mm_if.sv - Avalon-MM signal bundle with master/slave modports
interface avalon_mm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/amm_sc_fifo.sv
// rtl/amm_sc_fifo.sv - single-clock FIFO with registered full/empty flags
// Ports:
//   clk, resetn         clock, synchronous active-low reset (flushes pointers)
//   wr_en, wr_data      push request and data (ignored while full)
//   rd_en, rd_data      pop request and head data (ignored while empty)
//   full, empty, level  registered status flags and occupancy
module amm_sc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_nxt;
  logic [AW:0]      rd_ptr_nxt;
  logic             push;
  logic             pop;

  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  // Pointers carry one extra bit: equal low bits with differing top bit is full.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (push) wr_ptr_nxt = wr_ptr + (AW+1)'(1);
    if (pop)  rd_ptr_nxt = rd_ptr + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/amm_cmd_buffer.sv
// rtl/amm_cmd_buffer.sv - Avalon-MM command queue with outstanding-read limiter
// Ports:
//   clk_i, rst_i  clock, synchronous active-low reset
//   up_if         slave side facing the upstream master
//   dn_if         master side facing the width converter
//   level_o       queued command count
//   pend_o        outstanding read count
//   err_o         sticky protocol error (read+write together, stray response)
module amm_cmd_buffer
  import amm_cmd_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4,
  parameter int MAX_PEND = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  avalon_mm_if.slave                  up_if,
  avalon_mm_if.master                 dn_if,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic [$clog2(MAX_PEND):0]   pend_o,
  output logic                        err_o
);

  localparam int BE_W  = amm_be_w(DATA_W);
  localparam int CMD_W = 1 + ADDR_W + DATA_W + BE_W;
  localparam int PW    = $clog2(MAX_PEND) + 1;
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

  logic [CMD_W-1:0]  push_cmd;
  logic [CMD_W-1:0]  head_cmd;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic [BE_W-1:0]   head_be;

  logic              q_full;
  logic              q_empty;
  logic              accept;
  logic              pop;
  logic              read_gated;
  logic              rd_issue;
  logic              rsp_ok;
  logic              stray_rsp;
  logic              both_hi;

  logic [PW-1:0]     pend_q;
  logic              err_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  // Write wins when read and write arrive together; the error flag records it.
  assign push_cmd = {up_if.write, up_if.address, up_if.writedata, up_if.byteenable};
  assign {head_we, head_addr, head_wdata, head_be} = head_cmd;

  assign up_if.waitrequest = q_full | ~rst_i;
  assign accept            = (up_if.read | up_if.write) & ~up_if.waitrequest;
  assign both_hi           = accept & up_if.read & up_if.write;

  amm_sc_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .resetn  (rst_i),
    .wr_en   (accept),
    .wr_data (push_cmd),
    .rd_en   (pop),
    .rd_data (head_cmd),
    .full    (q_full),
    .empty   (q_empty),
    .level   (level_o)
  );

  // A read at the head waits for a free pending slot; everything behind it waits too.
  assign read_gated = ~head_we & (pend_q == PEND_MAX);

  assign dn_if.read       = rst_i & ~q_empty & ~head_we & ~read_gated;
  assign dn_if.write      = rst_i & ~q_empty & head_we;
  assign dn_if.address    = head_addr;
  assign dn_if.writedata  = head_wdata;
  assign dn_if.byteenable = head_be;

  assign pop       = (dn_if.read | dn_if.write) & ~dn_if.waitrequest;
  assign rd_issue  = pop & ~head_we;
  assign rsp_ok    = dn_if.readdatavalid & (pend_q != '0);
  assign stray_rsp = dn_if.readdatavalid & (pend_q == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pend_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case ({rd_issue, rsp_ok})
        2'b10:   pend_q <= pend_q + PW'(1);
        2'b01:   pend_q <= pend_q - PW'(1);
        default: pend_q <= pend_q;
      endcase
      err_q       <= err_q | stray_rsp | both_hi;
      // Stray responses are dropped, so neither valid nor data moves upstream.
      rsp_valid_q <= rsp_ok;
      if (rsp_ok) rsp_data_q <= dn_if.readdata;
    end
  end

  assign up_if.readdatavalid = rsp_valid_q;
  assign up_if.readdata      = rsp_data_q;
  assign pend_o              = pend_q;
  assign err_o               = err_q;

endmodule
